sync_downcounter_4bit: RTL and testbench



---
 rtl/sync_downcounter_4bit_pkg.sv | 5 +
 rtl/sync_downcounter_4bit_t_ff_sync.sv | 20 ++
 rtl/sync_downcounter_4bit.sv | 74 +++++++
 tb/tb_sync_downcounter_4bit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sync_downcounter_4bit_pkg.sv
// Shared sizing defaults for the lab's synchronous counters.
package sync_downcounter_4bit_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_MOD   = 16;
endpackage

// File: rtl/sync_downcounter_4bit_t_ff_sync.sv
// Falling-edge T flip-flop with synchronous active-low clear (wins) and preset.
module t_ff_sync (
    input  logic i_clk,
    input  logic i_clr_bar,
    input  logic i_pre_bar,
    input  logic i_t,
    output logic o_q,
    output logic o_q_bar
);
    logic r_q;

    always_ff @(negedge i_clk) begin
        if (!i_clr_bar)      r_q <= 1'b0;
        else if (!i_pre_bar) r_q <= 1'b1;
        else if (i_t)        r_q <= ~r_q;
    end

    assign o_q     = r_q;
    assign o_q_bar = ~r_q;
endmodule

// File: rtl/sync_downcounter_4bit.sv
// Synchronous modulo-MOD down counter built from T flip-flops sharing one falling clock edge.
module sync_downcounter_4bit
    import sync_downcounter_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MOD   = DEFAULT_MOD
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             pre_bar,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             borrow,
    output logic             zero_pulse,
    output logic             load_err
);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

    logic [WIDTH:0]   w_chain;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_t;
    logic             w_din_ok;
    logic             r_zero_pulse;
    logic             r_load_err;

    // Bit i toggles on a decrement exactly when every lower bit is zero.
    assign w_chain[0] = en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_chain[i+1] = w_chain[i] & ~Q[i];

        // Bits that are 0 in MOD-1 get cleared through the toggle path instead.
        t_ff_sync u_tff (
            .i_clk     (clk),
            .i_clr_bar (clr_bar),
            .i_pre_bar (TOP[i] ? pre_bar : 1'b1),
            .i_t       (w_t[i]),
            .o_q       (Q[i]),
            .o_q_bar   (Q_bar[i])
        );
    end

    assign borrow     = w_chain[WIDTH];
    assign w_din_ok   = ({1'b0, din} < MOD_W);
    assign w_load_val = w_din_ok ? din : TOP;

    // Loads and the wrap are expressed as toggles towards the target value.
    always_comb begin
        w_t = w_chain[WIDTH-1:0];
        if (!pre_bar)    w_t = Q ^ TOP;
        else if (load)   w_t = Q ^ w_load_val;
        else if (borrow) w_t = TOP;
    end

    always_ff @(negedge clk) begin
        if (!clr_bar || !pre_bar) begin
            r_zero_pulse <= 1'b0;
            r_load_err   <= 1'b0;
        end else if (load) begin
            r_zero_pulse <= 1'b0;
            r_load_err   <= ~w_din_ok;
        end else begin
            r_zero_pulse <= en & (Q == WIDTH'(1));
            r_load_err   <= 1'b0;
        end
    end

    assign zero_pulse = r_zero_pulse;
    assign load_err   = r_load_err;
endmodule

// File: tb/tb_sync_downcounter_4bit.sv
// Bench for sync_downcounter_4bit: vector table, hand sequences, cascade and randomized model check.
module tb_sync_downcounter_4bit;
    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       clr_bar = 1'b0, pre_bar = 1'b1, load = 1'b0, en = 1'b0;
    logic [3:0] din = 4'd0;
    logic [3:0] q16, qb16, q10, qb10;
    logic       b16, zp16, le16, b10, zp10, le10;

    logic       c_clr_bar = 1'b0, c_pre_bar = 1'b1, c_load = 1'b0, c_en = 1'b0;
    logic [3:0] c_din_lo = 4'd0, c_din_hi = 4'd0;
    logic [3:0] ql, qbl, qh, qbh;
    logic       bl, zpl, lel, bh, zph, leh;

    int vectors = 0;
    int miscompares = 0;

    sync_downcounter_4bit #(.WIDTH(4), .MOD(16)) dut (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_bar), .en(en), .load(load), .din(din),
        .Q(q16), .Q_bar(qb16), .borrow(b16), .zero_pulse(zp16), .load_err(le16));

    sync_downcounter_4bit #(.WIDTH(4), .MOD(10)) dut10 (
        .clk(clk), .clr_bar(clr_bar), .pre_bar(pre_bar), .en(en), .load(load), .din(din),
        .Q(q10), .Q_bar(qb10), .borrow(b10), .zero_pulse(zp10), .load_err(le10));

    sync_downcounter_4bit #(.WIDTH(4), .MOD(16)) u_lo (
        .clk(clk), .clr_bar(c_clr_bar), .pre_bar(c_pre_bar), .en(c_en), .load(c_load), .din(c_din_lo),
        .Q(ql), .Q_bar(qbl), .borrow(bl), .zero_pulse(zpl), .load_err(lel));

    sync_downcounter_4bit #(.WIDTH(4), .MOD(16)) u_hi (
        .clk(clk), .clr_bar(c_clr_bar), .pre_bar(c_pre_bar), .en(bl), .load(c_load), .din(c_din_hi),
        .Q(qh), .Q_bar(qbh), .borrow(bh), .zero_pulse(zph), .load_err(leh));

    typedef struct {
        logic       clr_bar, pre_bar, load, en;
        logic [3:0] din, q;
        logic       zp, le, b;
    } vec_t;

    function automatic vec_t mk(logic c, logic p, logic l, logic e, logic [3:0] d,
                                logic [3:0] q, logic zp, logic le, logic b);
        vec_t v;
        v.clr_bar = c; v.pre_bar = p; v.load = l; v.en = e; v.din = d;
        v.q = q; v.zp = zp; v.le = le; v.b = b;
        return v;
    endfunction

    task automatic step(logic c, logic p, logic l, logic e, logic [3:0] d);
        clr_bar = c; pre_bar = p; load = l; en = e; din = d;
        @(negedge clk);
        #1;
    endtask

    task automatic check(string name, logic [3:0] q, logic [3:0] qb, logic b, logic zp, logic le,
                         logic [3:0] eq, logic eb, logic ezp, logic ele);
        logic [3:0] eqb;
        eqb = ~eq;
        vectors++;
        if (q !== eq || qb !== eqb || b !== eb || zp !== ezp || le !== ele) begin
            miscompares++;
            $display("FAIL %s: got Q=%0d Q_bar=%0d borrow=%b zero_pulse=%b load_err=%b, need Q=%0d Q_bar=%0d borrow=%b zero_pulse=%b load_err=%b",
                     name, q, qb, b, zp, le, eq, eqb, eb, ezp, ele);
        end
    endtask

    task automatic ref_next(input int m, input int q, input logic c, input logic p, input logic l,
                            input logic e, input int d, output int nq, output logic zp, output logic le);
        zp = 1'b0; le = 1'b0; nq = q;
        if (!c)      nq = 0;
        else if (!p) nq = m - 1;
        else if (l) begin
            if (d < m) nq = d;
            else begin nq = m - 1; le = 1'b1; end
        end else if (e) begin
            nq = (q + m - 1) % m;
            zp = (q == 1);
        end
    endtask

    vec_t tbl[18];

    initial begin
        int m16, m10, n16, n10;
        logic z16, z10, e16, e10, rc, rp, rl, re;
        logic [3:0] rd;

        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd13, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd2,  1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1,  1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0,  1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0,  1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd15, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9,  1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd9,  1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd7,  1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].clr_bar, tbl[i].pre_bar, tbl[i].load, tbl[i].en, tbl[i].din);
            check($sformatf("tbl%0d", i), q16, qb16, b16, zp16, le16,
                  tbl[i].q, tbl[i].b, tbl[i].zp, tbl[i].le);
        end

        // Modulus-10 instance: full count-down lap and out-of-range loads.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("m10_clr", q10, qb10, b10, zp10, le10, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            logic [3:0] eq;
            eq = (k < 10) ? 4'(9 - k) : 4'd9;
            step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
            check($sformatf("m10_cnt%0d", k), q10, qb10, b10, zp10, le10, eq, k == 9, k == 9, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd12);
        check("m10_ld12", q10, qb10, b10, zp10, le10, 4'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd12);
        check("m10_hold", q10, qb10, b10, zp10, le10, 4'd9, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
        check("m10_ld10", q10, qb10, b10, zp10, le10, 4'd9, 1'b1 & 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd9);
        check("m10_ld9", q10, qb10, b10, zp10, le10, 4'd9, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check("m10_ld0", q10, qb10, b10, zp10, le10, 4'd0, 1'b0, 1'b0, 1'b0);

        // Two-stage cascade: 0x10 -> 0x0F -> 0x0E.
        c_clr_bar = 1'b1; c_load = 1'b1; c_din_lo = 4'd0; c_din_hi = 4'd1; c_en = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ev, got;
            ev = (k == 0) ? 8'h10 : ((k == 1) ? 8'h0F : 8'h0E);
            got = {qh, ql};
            vectors++;
            if (got !== ev || {qbh, qbl} !== ~ev) begin
                miscompares++;
                $display("FAIL cascade%0d: got 0x%02h, need 0x%02h", k, got, ev);
            end
            c_load = 1'b0; c_en = 1'b1;
            @(negedge clk); #1;
        end

        // Randomized run of both instances against the arithmetic model.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        m16 = 0; m10 = 0;
        for (int n = 0; n < 400; n++) begin
            rc = ($urandom_range(0, 19) != 0);
            rp = ($urandom_range(0, 19) != 0);
            rl = ($urandom_range(0, 6) == 0);
            re = ($urandom_range(0, 3) != 0);
            rd = 4'($urandom_range(0, 15));
            ref_next(16, m16, rc, rp, rl, re, int'(rd), n16, z16, e16);
            ref_next(10, m10, rc, rp, rl, re, int'(rd), n10, z10, e10);
            step(rc, rp, rl, re, rd);
            m16 = n16; m10 = n10;
            check($sformatf("rnd16_%0d", n), q16, qb16, b16, zp16, le16, 4'(m16), re & (m16 == 0), z16, e16);
            check($sformatf("rnd10_%0d", n), q10, qb10, b10, zp10, le10, 4'(m10), re & (m10 == 0), z10, e10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
